// File: rtl/ds_video_timing_gen_pkg.sv
// ds_pkg: shared types and constants for the downscaler test-pattern source.
//   pattern_sel_t : test pattern selector (bars, ramp, grey, checker)
//   BAR_RGB       : on/off mask {r,g,b} for the 8 colour bars, left to right
//   DEF_*         : default 640x480 raster timing
//   h_total/v_total : total clocks per line / lines per frame
package ds_pkg;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_GREY  = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_sel_t;

   // white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int h_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/ds_video_timing_gen_if.sv
// ds_video_timing_gen_if: video bus from the pattern source to the DS chain.
//   o_vsync, o_hsync : active-high syncs
//   o_de             : data enable (active pixels)
//   o_r/g/b_data     : WIDTH-bit colour components, 0 outside active video
//   o_frame_start    : one-clock pulse on pixel (0,0)
// Modports: master drives the bus (source), slave observes it (sink).
interface ds_video_timing_gen_if #(
   parameter int WIDTH = 10
);
   logic             o_vsync;
   logic             o_hsync;
   logic             o_de;
   logic [WIDTH-1:0] o_r_data;
   logic [WIDTH-1:0] o_g_data;
   logic [WIDTH-1:0] o_b_data;
   logic             o_frame_start;

   modport master (output o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start);
   modport slave  (input  o_vsync, o_hsync, o_de, o_r_data, o_g_data, o_b_data, o_frame_start);
endinterface

// File: rtl/ds_video_timing_gen_pattern_pix.sv
// ds_pattern_pix: combinational test-pattern pixel generator.
//   i_x       in  XW     horizontal position (already scrolled, < H_ACTIVE when used)
//   i_y       in  YW     vertical position
//   i_pattern in  2      pattern selector
//   o_r/g/b   out WIDTH  colour components
module ds_pattern_pix
   import ds_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int XW       = 10,
   parameter int YW       = 10
) (
   input  logic [XW-1:0]    i_x,
   input  logic [YW-1:0]    i_y,
   input  pattern_sel_t     i_pattern,
   output logic [WIDTH-1:0] o_r,
   output logic [WIDTH-1:0] o_g,
   output logic [WIDTH-1:0] o_b
);
   localparam int RW    = WIDTH + $clog2(H_ACTIVE);
   localparam int BAR_W = H_ACTIVE / 8;
   localparam logic [WIDTH-1:0] PIX_MAX  = '1;
   localparam logic [WIDTH-1:0] PIX_GREY = {1'b1, {(WIDTH-1){1'b0}}};

   logic [RW-1:0]    ramp_q;
   logic [WIDTH-1:0] ramp_v;
   logic [2:0]       bar_idx;
   logic [2:0]       bar_rgb;
   logic             chk;

   always_comb begin
      ramp_q  = (RW'(i_x) * RW'(PIX_MAX)) / RW'(H_ACTIVE - 1);
      ramp_v  = WIDTH'(ramp_q);
      bar_idx = 3'(i_x / XW'(BAR_W));
      bar_rgb = BAR_RGB[bar_idx];
      // widen before taking bit 4 so small rasters still index a real bit
      chk     = 1'((XW+5)'(i_x) >> 4) ^ 1'((YW+5)'(i_y) >> 4);
      o_r = '0;
      o_g = '0;
      o_b = '0;
      case (i_pattern)
         PAT_BARS: begin
            o_r = {WIDTH{bar_rgb[2]}};
            o_g = {WIDTH{bar_rgb[1]}};
            o_b = {WIDTH{bar_rgb[0]}};
         end
         PAT_RAMP: begin
            o_r = ramp_v;
            o_g = ramp_v;
            o_b = ramp_v;
         end
         PAT_GREY: begin
            o_r = PIX_GREY;
            o_g = PIX_GREY;
            o_b = PIX_GREY;
         end
         PAT_CHECK: begin
            o_r = chk ? PIX_MAX : '0;
            o_g = chk ? PIX_MAX : '0;
            o_b = chk ? PIX_MAX : '0;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/ds_video_timing_gen.sv
// ds_video_timing_gen: raster timing + RGB test pattern source for the DS chain.
//   clk            in   pixel clock
//   rst            in   asynchronous reset, active-high
//   i_en           in   run enable; low holds the raster at the origin
//   i_pattern_sel  in   0 bars, 1 ramp, 2 grey, 3 checker (latched per frame)
//   vid            master modport: syncs, de, R/G/B, frame_start (all registered)
// Optional feature: define DS_PATGEN_SCROLL_EN to scroll patterns horizontally
// by one pixel per frame.
module ds_video_timing_gen
   import ds_pkg::*;
#(
   parameter int WIDTH    = 10,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_en,
   input  logic [1:0]           i_pattern_sel,
   ds_video_timing_gen_if.master vid
);
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

   logic [HW-1:0]    h_cnt;
   logic [VW-1:0]    v_cnt;
   pattern_sel_t     pat_q;
   pattern_sel_t     pat_cur;
   logic             at_origin;
   logic             de_c;
   logic             h_sync_c;
   logic             v_sync_c;
   logic [HW-1:0]    x_pix;
   logic [WIDTH-1:0] pix_r;
   logic [WIDTH-1:0] pix_g;
   logic [WIDTH-1:0] pix_b;

   always_comb begin
      at_origin = (h_cnt == '0) && (v_cnt == '0);
      de_c      = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      h_sync_c  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      v_sync_c  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
      // the origin pixel uses the selector directly, so a new pattern covers
      // the whole frame including pixel (0,0)
      pat_cur   = at_origin ? pattern_sel_t'(i_pattern_sel) : pat_q;
   end

`ifdef DS_PATGEN_SCROLL_EN
   localparam int OW = $clog2(H_ACTIVE);
   localparam logic [OW-1:0] OFF_LAST = OW'(H_ACTIVE - 1);

   logic [OW-1:0] offset;
   logic [HW:0]   x_sum;

   // offset steps at each frame wrap, so the first frame after enable uses 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset <= '0;
      end else if (!i_en) begin
         offset <= '0;
      end else if (h_cnt == H_LAST && v_cnt == V_LAST) begin
         offset <= (offset == OFF_LAST) ? '0 : offset + 1'b1;
      end
   end

   always_comb begin
      x_sum = {1'b0, h_cnt} + (HW+1)'(offset);
      x_pix = (x_sum >= (HW+1)'(H_ACTIVE)) ? HW'(x_sum - (HW+1)'(H_ACTIVE)) : HW'(x_sum);
   end
`else
   always_comb x_pix = h_cnt;
`endif

   ds_pattern_pix #(
      .WIDTH    (WIDTH),
      .H_ACTIVE (H_ACTIVE),
      .XW       (HW),
      .YW       (VW)
   ) u_pix (
      .i_x       (x_pix),
      .i_y       (v_cnt),
      .i_pattern (pat_cur),
      .o_r       (pix_r),
      .o_g       (pix_g),
      .o_b       (pix_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt             <= '0;
         v_cnt             <= '0;
         pat_q             <= PAT_BARS;
         vid.o_vsync       <= 1'b0;
         vid.o_hsync       <= 1'b0;
         vid.o_de          <= 1'b0;
         vid.o_frame_start <= 1'b0;
         vid.o_r_data      <= '0;
         vid.o_g_data      <= '0;
         vid.o_b_data      <= '0;
      end else if (!i_en) begin
         h_cnt             <= '0;
         v_cnt             <= '0;
         vid.o_vsync       <= 1'b0;
         vid.o_hsync       <= 1'b0;
         vid.o_de          <= 1'b0;
         vid.o_frame_start <= 1'b0;
         vid.o_r_data      <= '0;
         vid.o_g_data      <= '0;
         vid.o_b_data      <= '0;
      end else begin
         vid.o_vsync       <= v_sync_c;
         vid.o_hsync       <= h_sync_c;
         vid.o_de          <= de_c;
         vid.o_frame_start <= at_origin;
         vid.o_r_data      <= de_c ? pix_r : '0;
         vid.o_g_data      <= de_c ? pix_g : '0;
         vid.o_b_data      <= de_c ? pix_b : '0;
         if (at_origin) pat_q <= pattern_sel_t'(i_pattern_sel);
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ds_video_timing_gen.sv
// Self-checking bench for ds_video_timing_gen on a 16x4 active raster
// (24 clocks/line, 8 lines/frame). Expected pixels are queued per frame;
// a monitor pops one entry for every sampled active pixel.
module tb_ds_video_timing_gen;
   localparam int WIDTH = 10;

   typedef struct {
      int r;
      int g;
      int b;
      int fs;
      int x;
      int y;
   } exp_t;

   localparam int RAMP_TAB [16] = '{0, 68, 136, 204, 272, 341, 409, 477,
                                    545, 613, 682, 750, 818, 886, 954, 1023};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       i_en = 1'b1;
   logic [1:0] i_pattern_sel = 2'd0;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_pix    = 0;
   exp_t exp_q [$];
   exp_t mon_e;

   ds_video_timing_gen_if #(.WIDTH(WIDTH)) vid ();

   ds_video_timing_gen #(
      .WIDTH    (WIDTH),
      .H_ACTIVE (16),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (3),
      .V_ACTIVE (4),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_en          (i_en),
      .i_pattern_sel (i_pattern_sel),
      .vid           (vid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t exp_pix(input int pat, input int x, input int y);
      exp_t e;
      e.x = x; e.y = y; e.fs = (x == 0 && y == 0) ? 1 : 0;
      e.r = 0; e.g = 0; e.b = 0;
      case (pat)
         0: case (x / 2)
               0: begin e.r = 1023; e.g = 1023; e.b = 1023; end
               1: begin e.r = 1023; e.g = 1023; e.b = 0;    end
               2: begin e.r = 0;    e.g = 1023; e.b = 1023; end
               3: begin e.r = 0;    e.g = 1023; e.b = 0;    end
               4: begin e.r = 1023; e.g = 0;    e.b = 1023; end
               5: begin e.r = 1023; e.g = 0;    e.b = 0;    end
               6: begin e.r = 0;    e.g = 0;    e.b = 1023; end
               default: ;
            endcase
         1: begin e.r = RAMP_TAB[x]; e.g = RAMP_TAB[x]; e.b = RAMP_TAB[x]; end
         2: begin e.r = 512; e.g = 512; e.b = 512; end
         default: ;  // checker: x,y < 16 so x[4]^y[4] = 0 everywhere
      endcase
      return e;
   endfunction

   task automatic push_frame(input int pat);
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 16; x++)
            exp_q.push_back(exp_pix(pat, x, y));
   endtask

   // monitor: one queue entry per active pixel
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && vid.o_de) begin
            n_pix++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL pix_unexpected: de=1 with r=%0d g=%0d b=%0d, expected no active pixel",
                        vid.o_r_data, vid.o_g_data, vid.o_b_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (int'(vid.o_r_data) != mon_e.r || int'(vid.o_g_data) != mon_e.g ||
                   int'(vid.o_b_data) != mon_e.b || int'(vid.o_frame_start) != mon_e.fs) begin
                  n_fail++;
                  $display("FAIL pix(x=%0d,y=%0d): got r=%0d g=%0d b=%0d fs=%0d, expected r=%0d g=%0d b=%0d fs=%0d",
                           mon_e.x, mon_e.y, vid.o_r_data, vid.o_g_data, vid.o_b_data,
                           vid.o_frame_start, mon_e.r, mon_e.g, mon_e.b, mon_e.fs);
               end
            end
         end
      end
   end

   task automatic wait_fs(output bit found, output int waited);
      found = 1'b0;
      waited = 0;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk); #1;
         if (vid.o_frame_start) begin
            found = 1'b1;
            waited = i;
            return;
         end
      end
   endtask

   // Called on the frame_start sample (k=0); walks one 192-clock frame.
   task automatic measure_frame(input int frame_no, input int chg_k, input int chg_pat, input int abort_k);
      int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, blank_nz = 0;
      for (int k = 0; k < 192; k++) begin
         if (k > 0) begin @(negedge clk); #1; end
         de_cnt += int'(vid.o_de);
         hs_cnt += int'(vid.o_hsync);
         vs_cnt += int'(vid.o_vsync);
         fs_cnt += int'(vid.o_frame_start);
         if (!vid.o_de && (vid.o_r_data != '0 || vid.o_g_data != '0 || vid.o_b_data != '0))
            blank_nz++;
         if (frame_no == 0) begin
            case (k)
               15:  check("line0_de_last",  int'(vid.o_de), 1);
               16:  check("line0_de_off",   int'(vid.o_de), 0);
               17:  check("hsync_before",   int'(vid.o_hsync), 0);
               18:  check("hsync_first",    int'(vid.o_hsync), 1);
               20:  check("hsync_last",     int'(vid.o_hsync), 1);
               21:  check("hsync_after",    int'(vid.o_hsync), 0);
               119: check("vsync_before",   int'(vid.o_vsync), 0);
               120: check("vsync_first",    int'(vid.o_vsync), 1);
               167: check("vsync_last",     int'(vid.o_vsync), 1);
               168: check("vsync_after",    int'(vid.o_vsync), 0);
               default: ;
            endcase
         end
         if (k == chg_k) begin
            i_pattern_sel = 2'(chg_pat);
            push_frame(chg_pat);
         end
         if (k == abort_k) begin
            i_en = 1'b0;
            return;
         end
      end
      check($sformatf("f%0d_de_count", frame_no), de_cnt, 64);
      check($sformatf("f%0d_hsync_count", frame_no), hs_cnt, 24);
      check($sformatf("f%0d_vsync_count", frame_no), vs_cnt, 48);
      check($sformatf("f%0d_fs_count", frame_no), fs_cnt, 1);
      check($sformatf("f%0d_blank_rgb_nonzero", frame_no), blank_nz, 0);
      @(negedge clk); #1;
      check($sformatf("f%0d_frame_period", frame_no), int'(vid.o_frame_start), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run still active at time %0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      int waited;

      rst = 1'b1;
      i_en = 1'b1;
      i_pattern_sel = 2'd0;
      repeat (5) @(posedge clk);
      @(negedge clk); #1;
      check("rst_vsync", int'(vid.o_vsync), 0);
      check("rst_hsync", int'(vid.o_hsync), 0);
      check("rst_de",    int'(vid.o_de), 0);
      check("rst_fs",    int'(vid.o_frame_start), 0);
      check("rst_rgb",   int'(vid.o_r_data) + int'(vid.o_g_data) + int'(vid.o_b_data), 0);

      push_frame(0);
      @(negedge clk);
      rst = 1'b0;
      wait_fs(found, waited);
      check("first_fs_found", int'(found), 1);
      check("first_fs_latency", waited, 1);

      measure_frame(0, 100, 1, -1);   // bars; queue ramp for next frame
      measure_frame(1, 100, 2, -1);   // ramp; queue grey
      measure_frame(2, 30, 3, -1);    // grey; switch to checker mid-active
      measure_frame(3, -1, 0, 30);    // checker; drop enable at line 1, x=6

      @(negedge clk); #1;
      check("en_off_de",  int'(vid.o_de), 0);
      check("en_off_fs",  int'(vid.o_frame_start), 0);
      check("en_off_rgb", int'(vid.o_r_data) + int'(vid.o_g_data) + int'(vid.o_b_data), 0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      #1;
      check("en_off_hold_de", int'(vid.o_de), 0);

      i_pattern_sel = 2'd1;
      push_frame(1);
      i_en = 1'b1;
      @(negedge clk); #1;
      check("restart_fs", int'(vid.o_frame_start), 1);
      check("restart_de", int'(vid.o_de), 1);
      measure_frame(4, 100, 1, -1);   // ramp after restart; queue one more

      i_en = 1'b0;
      @(negedge clk); #1;
      exp_q.delete();
      // 3 full frames + 23 pixels before abort + 64 after restart + 1 origin pixel
      check("total_pixels", n_pix, 280);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
